// File: rtl/guarded_state_fsm.sv
// guarded_state_fsm: user-requested state machine with a transition policy,
// an idle timeout back to a safe state, recovery from corrupt state encodings
// and a terminal lock state that only reset can leave.

module guarded_state_fsm #(
  parameter int STATE_W     = 3,
  parameter int NUM_STATES  = 5,
  parameter int SAFE_STATE  = 0,
  parameter int LOCK_STATE  = 4,
  parameter logic [NUM_STATES*NUM_STATES-1:0] TRANS_MASK = '1,
  parameter int TIMEOUT_CYC = 0,
  parameter int DBG_EN      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [STATE_W-1:0] req_state,
  output logic               req_ready,
  output logic [STATE_W-1:0] out,
  output logic               locked,
  output logic               err_illegal,
  output logic               timeout,
  output logic               err_fault,
  input  logic               dbg_inject,
  input  logic [STATE_W-1:0] dbg_state
);

  // Parameter sanity: refuse to elaborate a configuration that cannot work.
  if (STATE_W < 1) begin : g_bad_width
    $error("guarded_state_fsm: STATE_W must be at least 1");
  end
  if (NUM_STATES < 2 || NUM_STATES > (1 << STATE_W)) begin : g_bad_num
    $error("guarded_state_fsm: NUM_STATES must be in 2..2**STATE_W");
  end
  if (SAFE_STATE < 0 || SAFE_STATE >= NUM_STATES) begin : g_bad_safe
    $error("guarded_state_fsm: SAFE_STATE must be a legal state");
  end
  if (LOCK_STATE < 0 || LOCK_STATE >= NUM_STATES || LOCK_STATE == SAFE_STATE) begin : g_bad_lock
    $error("guarded_state_fsm: LOCK_STATE must be legal and differ from SAFE_STATE");
  end
  if (TIMEOUT_CYC < 0) begin : g_bad_timeout
    $error("guarded_state_fsm: TIMEOUT_CYC must not be negative");
  end
  if (DBG_EN != 0 && DBG_EN != 1) begin : g_bad_dbg
    $error("guarded_state_fsm: DBG_EN must be 0 or 1");
  end

  // The timer only has to reach TIMEOUT_CYC-1, so it is sized for that.
  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    TIMER_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  // One extra bit so NUM_STATES == 2**STATE_W still compares correctly.
  localparam logic [STATE_W:0]   NUM_S  = (STATE_W+1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] SAFE_S = STATE_W'(SAFE_STATE);
  localparam logic [STATE_W-1:0] LOCK_S = STATE_W'(LOCK_STATE);
  localparam logic               TIMER_ON = (TIMEOUT_CYC != 0);
  localparam logic               DBG_ON   = (DBG_EN != 0);

  logic [TIMER_W-1:0] timer;
  logic               state_bad;
  logic               req_in_range;
  logic               mask_ok;
  logic               accept;
  logic               req_legal;
  logic               inject_en;
  logic               timer_run;

  assign state_bad    = ({1'b0, out} >= NUM_S);
  assign req_in_range = ({1'b0, req_state} < NUM_S);
  assign req_ready    = !locked && !state_bad;
  assign accept       = req_valid && req_ready;
  assign req_legal    = req_in_range && mask_ok;
  assign inject_en    = DBG_ON && dbg_inject && !locked;
  assign timer_run    = TIMER_ON && !state_bad && (out != SAFE_S) && (out != LOCK_S);

  // Look up the policy bit for the current (from, to) pair; leaving LOCK is never allowed.
  always_comb begin
    mask_ok = 1'b0;
    for (int f = 0; f < NUM_STATES; f++) begin
      for (int t = 0; t < NUM_STATES; t++) begin
        if (f != LOCK_STATE && out == STATE_W'(f) && req_state == STATE_W'(t)) begin
          mask_ok = TRANS_MASK[f*NUM_STATES + t];
        end
      end
    end
  end

  // State register and registered flags, updated in priority order:
  // reset, debug inject, fault recovery, accept, timeout, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= SAFE_S;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      timeout     <= 1'b0;
      err_fault   <= 1'b0;
      timer       <= '0;
    end else begin
      err_illegal <= 1'b0;
      timeout     <= 1'b0;
      if (inject_en) begin
        out    <= dbg_state;
        locked <= (dbg_state == LOCK_S);
        timer  <= '0;
      end else if (state_bad) begin
        out       <= SAFE_S;
        locked    <= 1'b0;
        err_fault <= 1'b1;
        timer     <= '0;
      end else if (accept) begin
        timer <= '0;
        if (req_legal) begin
          out    <= req_state;
          locked <= (req_state == LOCK_S);
        end else begin
          err_illegal <= 1'b1;
        end
      end else if (timer_run && timer == TIMER_LAST) begin
        out     <= SAFE_S;
        locked  <= 1'b0;
        timeout <= 1'b1;
        timer   <= '0;
      end else if (timer_run) begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_guarded_state_fsm.sv
// tb_guarded_state_fsm: directed scenarios for guarded_state_fsm on two
// instances: one with a restricted transition mask and debug inject enabled,
// one with a 4-cycle idle timeout and debug inject disabled.

module tb_guarded_state_fsm;

  logic clk;
  int   tests_run;
  int   tests_failed;

  // Instance A: mask bit 1->3 cleared, no timeout, debug inject enabled.
  logic       a_rst, a_req_valid, a_req_ready, a_locked, a_err_illegal, a_timeout, a_err_fault;
  logic       a_dbg_inject;
  logic [2:0] a_req_state, a_out, a_dbg_state;

  // Instance T: full mask, 4-cycle timeout, debug inject disabled.
  logic       t_rst, t_req_valid, t_req_ready, t_locked, t_err_illegal, t_timeout, t_err_fault;
  logic       t_dbg_inject;
  logic [2:0] t_req_state, t_out, t_dbg_state;

  guarded_state_fsm #(
    .STATE_W(3), .NUM_STATES(5), .SAFE_STATE(0), .LOCK_STATE(4),
    .TRANS_MASK(25'h1FF_FEFF), .TIMEOUT_CYC(0), .DBG_EN(1)
  ) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_state(a_req_state),
    .req_ready(a_req_ready), .out(a_out), .locked(a_locked),
    .err_illegal(a_err_illegal), .timeout(a_timeout), .err_fault(a_err_fault),
    .dbg_inject(a_dbg_inject), .dbg_state(a_dbg_state)
  );

  guarded_state_fsm #(
    .STATE_W(3), .NUM_STATES(5), .SAFE_STATE(0), .LOCK_STATE(4),
    .TRANS_MASK({25{1'b1}}), .TIMEOUT_CYC(4), .DBG_EN(0)
  ) dut_t (
    .clk(clk), .rst(t_rst), .req_valid(t_req_valid), .req_state(t_req_state),
    .req_ready(t_req_ready), .out(t_out), .locked(t_locked),
    .err_illegal(t_err_illegal), .timeout(t_timeout), .err_fault(t_err_fault),
    .dbg_inject(t_dbg_inject), .dbg_state(t_dbg_state)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    tests_run++; if (a_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_out: got %0d want 0", a_out); end
    tests_run++; if (a_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_locked: got %b want 0", a_locked); end
    tests_run++; if (a_err_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err_illegal: got %b want 0", a_err_illegal); end
    tests_run++; if (a_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout: got %b want 0", a_timeout); end
    tests_run++; if (a_err_fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err_fault: got %b want 0", a_err_fault); end
    tests_run++; if (a_req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b want 1", a_req_ready); end
  endtask

  task automatic test_legal_request();
    a_req_valid = 1'b1; a_req_state = 3'd2;
    step();
    a_req_valid = 1'b0;
    tests_run++; if (a_out !== 3'd2) begin tests_failed++; $display("[TB] FAIL legal_out: got %0d want 2", a_out); end
    tests_run++; if (a_err_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL legal_err_illegal: got %b want 0", a_err_illegal); end
  endtask

  task automatic test_out_of_range();
    a_req_valid = 1'b1; a_req_state = 3'd6;
    step();
    a_req_valid = 1'b0;
    tests_run++; if (a_out !== 3'd2) begin tests_failed++; $display("[TB] FAIL range_out: got %0d want 2", a_out); end
    tests_run++; if (a_err_illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL range_pulse: got %b want 1", a_err_illegal); end
    step();
    tests_run++; if (a_err_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL range_pulse_end: got %b want 0", a_err_illegal); end
    tests_run++; if (a_out !== 3'd2) begin tests_failed++; $display("[TB] FAIL range_hold: got %0d want 2", a_out); end
  endtask

  task automatic test_mask();
    a_req_valid = 1'b1; a_req_state = 3'd1;
    step();
    tests_run++; if (a_out !== 3'd1) begin tests_failed++; $display("[TB] FAIL mask_enter1: got %0d want 1", a_out); end
    a_req_state = 3'd3;
    step();
    tests_run++; if (a_out !== 3'd1) begin tests_failed++; $display("[TB] FAIL mask_block_out: got %0d want 1", a_out); end
    tests_run++; if (a_err_illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL mask_block_pulse: got %b want 1", a_err_illegal); end
    a_req_state = 3'd2;
    step();
    a_req_valid = 1'b0;
    tests_run++; if (a_out !== 3'd2) begin tests_failed++; $display("[TB] FAIL mask_allow_out: got %0d want 2", a_out); end
    tests_run++; if (a_err_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL mask_allow_pulse: got %b want 0", a_err_illegal); end
  endtask

  task automatic test_timeout();
    t_rst = 1'b1;
    step();
    t_rst = 1'b0;
    tests_run++; if (t_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL to_reset_out: got %0d want 0", t_out); end
    // Plain expiry: entered at one edge, back to 0 four edges later.
    t_req_valid = 1'b1; t_req_state = 3'd1;
    step();
    t_req_valid = 1'b0;
    step(); step(); step();
    tests_run++; if (t_out !== 3'd1) begin tests_failed++; $display("[TB] FAIL to_before_expiry: got %0d want 1", t_out); end
    tests_run++; if (t_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_no_early_pulse: got %b want 0", t_timeout); end
    step();
    tests_run++; if (t_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL to_expired_out: got %0d want 0", t_out); end
    tests_run++; if (t_timeout !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_pulse: got %b want 1", t_timeout); end
    step();
    tests_run++; if (t_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_pulse_end: got %b want 0", t_timeout); end
    // Restart: a self-request at idle cycle 3 restarts the count.
    t_req_valid = 1'b1; t_req_state = 3'd1;
    step();
    t_req_valid = 1'b0;
    step(); step();
    t_req_valid = 1'b1;
    step();
    t_req_valid = 1'b0;
    step();
    tests_run++; if (t_out !== 3'd1) begin tests_failed++; $display("[TB] FAIL to_restart_hold: got %0d want 1", t_out); end
    step(); step();
    tests_run++; if (t_out !== 3'd1) begin tests_failed++; $display("[TB] FAIL to_restart_late: got %0d want 1", t_out); end
    step();
    tests_run++; if (t_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL to_restart_expire: got %0d want 0", t_out); end
    tests_run++; if (t_timeout !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_restart_pulse: got %b want 1", t_timeout); end
    // A request landing on the expiry cycle wins over the timeout.
    t_req_valid = 1'b1; t_req_state = 3'd1;
    step();
    t_req_valid = 1'b0;
    step(); step(); step();
    t_req_valid = 1'b1; t_req_state = 3'd2;
    step();
    t_req_valid = 1'b0;
    tests_run++; if (t_out !== 3'd2) begin tests_failed++; $display("[TB] FAIL to_race_out: got %0d want 2", t_out); end
    tests_run++; if (t_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_race_pulse: got %b want 0", t_timeout); end
    // Reset in the middle of a count returns everything to idle.
    step();
    t_rst = 1'b1;
    step();
    t_rst = 1'b0;
    tests_run++; if (t_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL to_midreset_out: got %0d want 0", t_out); end
    tests_run++; if (t_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_midreset_pulse: got %b want 0", t_timeout); end
    // Inject is ignored when the debug port is disabled.
    t_dbg_inject = 1'b1; t_dbg_state = 3'd7;
    step();
    t_dbg_inject = 1'b0;
    step();
    tests_run++; if (t_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL to_nodbg_out: got %0d want 0", t_out); end
    tests_run++; if (t_err_fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_nodbg_fault: got %b want 0", t_err_fault); end
    // The timer stays idle in the lock state.
    t_req_valid = 1'b1; t_req_state = 3'd4;
    step();
    t_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    tests_run++; if (t_out !== 3'd4) begin tests_failed++; $display("[TB] FAIL to_lock_hold: got %0d want 4", t_out); end
    tests_run++; if (t_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_lock_pulse: got %b want 0", t_timeout); end
  endtask

  task automatic test_fault();
    a_dbg_inject = 1'b1; a_dbg_state = 3'd7;
    step();
    a_dbg_inject = 1'b0;
    tests_run++; if (a_out !== 3'd7) begin tests_failed++; $display("[TB] FAIL fault_inject_out: got %0d want 7", a_out); end
    tests_run++; if (a_req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fault_ready: got %b want 0", a_req_ready); end
    tests_run++; if (a_err_fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL fault_not_yet: got %b want 0", a_err_fault); end
    a_req_valid = 1'b1; a_req_state = 3'd2;
    step();
    a_req_valid = 1'b0;
    tests_run++; if (a_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL fault_recover_out: got %0d want 0", a_out); end
    tests_run++; if (a_err_fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL fault_flag: got %b want 1", a_err_fault); end
    a_req_valid = 1'b1; a_req_state = 3'd3;
    step();
    a_req_valid = 1'b0;
    tests_run++; if (a_out !== 3'd3) begin tests_failed++; $display("[TB] FAIL fault_traffic_out: got %0d want 3", a_out); end
    tests_run++; if (a_err_fault !== 1'b1) begin tests_failed++; $display("[TB] FAIL fault_sticky: got %b want 1", a_err_fault); end
  endtask

  task automatic test_lock();
    a_req_valid = 1'b1; a_req_state = 3'd4;
    step();
    tests_run++; if (a_out !== 3'd4) begin tests_failed++; $display("[TB] FAIL lock_out: got %0d want 4", a_out); end
    tests_run++; if (a_locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_flag: got %b want 1", a_locked); end
    tests_run++; if (a_req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_ready: got %b want 0", a_req_ready); end
    a_req_state = 3'd0;
    step();
    a_req_valid = 1'b0;
    tests_run++; if (a_out !== 3'd4) begin tests_failed++; $display("[TB] FAIL lock_req_ignored: got %0d want 4", a_out); end
    tests_run++; if (a_err_illegal !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_no_pulse: got %b want 0", a_err_illegal); end
    a_dbg_inject = 1'b1; a_dbg_state = 3'd1;
    step();
    a_dbg_inject = 1'b0;
    tests_run++; if (a_out !== 3'd4) begin tests_failed++; $display("[TB] FAIL lock_inject_ignored: got %0d want 4", a_out); end
    step(); step(); step();
    tests_run++; if (a_out !== 3'd4) begin tests_failed++; $display("[TB] FAIL lock_idle: got %0d want 4", a_out); end
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    tests_run++; if (a_out !== 3'd0) begin tests_failed++; $display("[TB] FAIL lock_reset_out: got %0d want 0", a_out); end
    tests_run++; if (a_locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_reset_flag: got %b want 0", a_locked); end
    tests_run++; if (a_err_fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_reset_fault: got %b want 0", a_err_fault); end
  endtask

  // Scenario sequence; instance T is held in reset until its own scenario.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    a_rst = 1'b1; a_req_valid = 1'b0; a_req_state = 3'd0; a_dbg_inject = 1'b0; a_dbg_state = 3'd0;
    t_rst = 1'b1; t_req_valid = 1'b0; t_req_state = 3'd0; t_dbg_inject = 1'b0; t_dbg_state = 3'd0;
    test_reset();
    test_legal_request();
    test_out_of_range();
    test_mask();
    test_fault();
    test_lock();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
